uart_tx_scheduler: RTL

- Shares one 8N1 UART transmit line between two byte requesters using round-robin arbitration.
- Generates its own bit timing from a sysclk divider, one tick per bit period, matching the 9600-baud timing used by the serial transceiver.
- Sits between command/echo sources and the board TX pin.
- Replaces free-running divided clocks with a single-clock, enable-based design.

---
 rtl/uart_tx_scheduler.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin 8N1 UART transmitter shared by two byte requesters.
// Bit timing comes from an enable-style divider on the single system clock.
module uart_tx_scheduler #(
  parameter int CLK_DIV = 10416
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [13:0] DIV_MAX = 14'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [13:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        tick;
  logic        win;

  assign tick = (div_q == DIV_MAX);
  // A tie goes to whoever did not win the previous tie.
  assign win  = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 14'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = START;
          ack0_d  = ~win;
          ack1_d  = win;
          grant_d = win;
          shift_d = win ? data1 : data0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          div_d   = '0;
          if (req0 & req1) begin
            last_d = win;
          end
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign grant_id = grant_q;

endmodule
